// File: rtl/ant_tick_scheduler.sv
// Per-tick sequencer for the ant array: strobes each ant's move, then drains sugar/pheromone writes one at a time onto the world write port, then re-arms all ants.
// Optional feature macro: PHEROMONE_DEPOSIT_EN (mouthFull ants deposit pheromone at their own location).
module ant_tick_scheduler #(
   parameter int unsigned N_ANTS = 8,
   parameter int unsigned X_bits = 8,
   parameter int unsigned Y_bits = 8
) (
   input  logic                     Clk,
   input  logic                     RESET,
   input  logic                     start,
   input  logic [N_ANTS*X_bits-1:0] ant_X,
   input  logic [N_ANTS*Y_bits-1:0] ant_Y,
   input  logic [N_ANTS-1:0]        ant_collecting,
   input  logic [N_ANTS-1:0]        ant_dropping,
   input  logic [N_ANTS-1:0]        ant_mouthFull,
   output logic [N_ANTS-1:0]        moveNow,
   output logic                     global_writing_flag,
   output logic                     wr_req,
   output logic [X_bits-1:0]        wr_X,
   output logic [Y_bits-1:0]        wr_Y,
   output logic [1:0]               wr_op,
   input  logic                     wr_ack,
   output logic                     busy,
   output logic                     tick_done,
   output logic [15:0]              sugar_count
);

   localparam int unsigned IDX_W = (N_ANTS > 1) ? $clog2(N_ANTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ANTS - 1);

   localparam logic [1:0] OP_PHEROMONE = 2'b00;
   localparam logic [1:0] OP_TAKE      = 2'b01;
   localparam logic [1:0] OP_DELIVER   = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      MOVE,
      SETTLE,
      WRITE,
      FLAG
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;

   // The ant whose write is loaded into the output registers at the next edge.
   logic [IDX_W-1:0]  eval_idx;
   logic              eval_need;
   logic [1:0]        eval_op;
   logic [X_bits-1:0] eval_x;
   logic [Y_bits-1:0] eval_y;

   assign eval_idx = ((state == SETTLE) || (idx == LAST_IDX)) ? '0 : idx + IDX_W'(1);

   // Fixed priority: a drop outranks a pickup, which outranks a deposit.
   always_comb begin
      eval_need = 1'b0;
      eval_op   = OP_PHEROMONE;
      if (ant_dropping[eval_idx]) begin
         eval_need = 1'b1;
         eval_op   = OP_DELIVER;
      end else if (ant_collecting[eval_idx]) begin
         eval_need = 1'b1;
         eval_op   = OP_TAKE;
      end
`ifdef PHEROMONE_DEPOSIT_EN
      else if (ant_mouthFull[eval_idx]) begin
         eval_need = 1'b1;
         eval_op   = OP_PHEROMONE;
      end
`endif
   end

`ifndef PHEROMONE_DEPOSIT_EN
   logic unused_mouth;
   assign unused_mouth = ^ant_mouthFull;
`endif

   always_comb begin
      eval_x = '0;
      eval_y = '0;
      if (eval_need) begin
         eval_x = ant_X[eval_idx * X_bits +: X_bits];
         eval_y = ant_Y[eval_idx * Y_bits +: Y_bits];
      end
   end

   always_ff @(posedge Clk) begin
      if (RESET) begin
         state               <= IDLE;
         idx                 <= '0;
         moveNow             <= '0;
         global_writing_flag <= 1'b0;
         wr_req              <= 1'b0;
         wr_X                <= '0;
         wr_Y                <= '0;
         wr_op               <= '0;
         busy                <= 1'b0;
         tick_done           <= 1'b0;
         sugar_count         <= '0;
      end else begin
         global_writing_flag <= 1'b0;
         tick_done           <= 1'b0;

         if (wr_req && wr_ack && (wr_op == OP_DELIVER) && (sugar_count != 16'hFFFF))
            sugar_count <= sugar_count + 16'd1;

         case (state)
            IDLE: begin
               if (start) begin
                  state   <= MOVE;
                  idx     <= '0;
                  moveNow <= N_ANTS'(1);
                  busy    <= 1'b1;
               end
            end

            MOVE: begin
               if (idx == LAST_IDX) begin
                  state   <= SETTLE;
                  idx     <= '0;
                  moveNow <= '0;
               end else begin
                  idx     <= idx + IDX_W'(1);
                  moveNow <= moveNow << 1;
               end
            end

            SETTLE: begin
               state  <= WRITE;
               wr_req <= eval_need;
               wr_X   <= eval_x;
               wr_Y   <= eval_y;
               wr_op  <= eval_op;
            end

            // A pending request holds its fields until acked; idle ants pass in one cycle.
            WRITE: begin
               if (!wr_req || wr_ack) begin
                  if (idx == LAST_IDX) begin
                     state               <= FLAG;
                     idx                 <= '0;
                     wr_req              <= 1'b0;
                     wr_X                <= '0;
                     wr_Y                <= '0;
                     wr_op               <= '0;
                     global_writing_flag <= 1'b1;
                     tick_done           <= 1'b1;
                  end else begin
                     idx    <= idx + IDX_W'(1);
                     wr_req <= eval_need;
                     wr_X   <= eval_x;
                     wr_Y   <= eval_y;
                     wr_op  <= eval_op;
                  end
               end
            end

            FLAG: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ant_tick_scheduler.md
# ant_tick_scheduler

Sequences one simulation tick for a bank of `ant` instances. It strobes each ant's `moveNow` in turn, then scans the ants and serialises their world-memory side effects (sugar pickup, sugar drop, optional pheromone deposit) onto a single write port. It then pulses `global_writing_flag` so every ant re-arms for the next tick. It sits between the top-level tick timer and the ant array / world memory arbiter.

## Interface
Parameters:
- `N_ANTS`, default 8: number of ants scheduled; index width is `$clog2(N_ANTS)`, minimum 1.
- `X_bits`, default 8: ant X coordinate width.
- `Y_bits`, default 8: ant Y coordinate width.

Ports:
- `Clk`  in  1  single clock; all logic on posedge.
- `RESET`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a tick; sampled only in IDLE.
- `ant_X`  in  N_ANTS×X_bits  packed current X of each ant.
- `ant_Y`  in  N_ANTS×Y_bits  packed current Y of each ant.
- `ant_collecting`  in  N_ANTS  per-ant `collecting_sugar`.
- `ant_dropping`  in  N_ANTS  per-ant `dropping_sugar`.
- `ant_mouthFull`  in  N_ANTS  per-ant `mouthFull`.
- `moveNow`  out  N_ANTS  one-hot move strobe.
- `global_writing_flag`  out  1  re-arm pulse to all ants.
- `wr_req`  out  1  world write request.
- `wr_X`  out  X_bits  write location X.
- `wr_Y`  out  Y_bits  write location Y.
- `wr_op`  out  2  00 pheromone deposit, 01 take sugar, 10 deliver sugar to nest.
- `wr_ack`  in  1  write accepted this cycle.
- `busy`  out  1  tick in progress.
- `tick_done`  out  1  one-cycle end-of-tick pulse.
- `sugar_count`  out  16  total acked deliveries, saturating.

## Operation
- States: IDLE, MOVE, SETTLE, WRITE, FLAG.
- IDLE: all strobes low. When `start`=1, clear `idx` and go to MOVE.
- MOVE: `moveNow[idx]`=1, all other bits 0. `idx`++ each cycle. After `idx`=N_ANTS-1, clear `idx` and go to SETTLE.
- SETTLE: one idle cycle so ant outputs reflect their post-move state. Go to WRITE.
- WRITE: evaluate ant `idx`. Its write need has fixed priority: dropping → op 10; else collecting → op 01; else (macro only) mouthFull → op 00; else none.
  - No need: advance `idx` the same cycle.
  - Need: `wr_req`=1 with `wr_X`/`wr_Y`/`wr_op` driven from ant `idx`, held stable until `wr_ack`=1. Advance `idx` on the ack cycle.
  - After the last ant completes, go to FLAG.
- FLAG: `global_writing_flag`=1 and `tick_done`=1 for exactly one cycle, then IDLE.
- `sugar_count` increments on each cycle with `wr_req`&&`wr_ack`&&`wr_op`==10. It holds at 16'hFFFF.
- `wr_ack` is ignored while `wr_req`=0.
- `start` is ignored outside IDLE.
- `busy` = (state != IDLE).
- `wr_X`/`wr_Y`/`wr_op` are 0 when `wr_req`=0.

## Timing
- Reset: state IDLE, `idx`=0, `sugar_count`=0. All outputs 0 in the cycle after `RESET` is sampled high. RESET mid-tick aborts immediately with no further strobes.
- With `start` sampled in cycle 0:
  - `moveNow[i]` is high in cycle 1+i.
  - SETTLE is cycle N_ANTS+1.
  - WRITE begins in cycle N_ANTS+2.
- Each ant costs 1 WRITE cycle, plus one cycle per ack-wait cycle if it needs a write.
- Zero-stall tick: FLAG in cycle 2·N_ANTS+2, with `busy` high in cycles 1..2·N_ANTS+2. For N_ANTS=8 this is FLAG at cycle 18.
- Back-to-back ticks: `start` held high re-triggers in the cycle after FLAG. IDLE lasts one cycle.

## Configuration
- `PHEROMONE_DEPOSIT_EN` defined: a mouthFull ant with no drop or collect issues an op-00 deposit at its own location.
- `PHEROMONE_DEPOSIT_EN` undefined: only sugar events generate writes, and op 00 never appears.

## Test plan
- N_ANTS=8, no sugar flags, `start` pulse at cycle 0 → `moveNow` walks 0x01..0x80 in cycles 1–8, no `wr_req`, `global_writing_flag`=`tick_done`=1 in cycle 18 only.
- Ant 3 `ant_dropping`=1 at (5,7), `wr_ack` delayed 3 cycles → `wr_req` held with (5,7, op 10) for 4 cycles; FLAG at cycle 21; `sugar_count`=1.
- Ant 2 has both `ant_collecting`=1 and `ant_dropping`=1 → a single op-10 write; no op-01 write for that ant.
- Macro on, ants 0 and 7 `ant_mouthFull`=1 (not dropping/collecting), immediate ack → two op-00 writes, in cycles 10 and 17. Macro off → no writes.
- `RESET` asserted in cycle 12 during a held `wr_req` → all outputs 0 from cycle 13, `busy`=0, `sugar_count`=0; a `start` in cycle 14 gives `moveNow`=0x01 in cycle 15.
- Preload `sugar_count` to 16'hFFFF via repeated drops, then one more acked drop → count stays 16'hFFFF.
